// File: rtl/gpio_reg_bus_initiator.sv
// Register-bus initiator: turns valid/ready commands into chip_sel/strobe/hold cycles for the
// GPIO/ADC/touch decoder and queues read data. Define GPIO_INIT_AUTOINC_EN for burst commands.
module gpio_reg_bus_initiator #(
  parameter int AddrWidth = 16,
  parameter int BusWidth  = 32,
  parameter int RdLatency = 4,
  parameter int WrHold    = 4,
  parameter int RspDepth  = 2
) (
  input  logic                 reg_clk,
  input  logic                 reset_in,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AddrWidth-3:0] cmd_addr,
  input  logic [BusWidth-1:0]  cmd_data,
`ifdef GPIO_INIT_AUTOINC_EN
  input  logic [3:0]           cmd_len,
`endif
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BusWidth-1:0]  rsp_data,
  output logic                 chip_sel,
  output logic                 write_reg,
  output logic                 read_reg,
  output logic [AddrWidth-3:0] busaddress,
  output logic [BusWidth-1:0]  busdata_out,
  input  logic [BusWidth-1:0]  busdata_from_dec,
  output logic                 busy,
  output logic [2:0]           o_dbg_state
);

  localparam int PtrW = $clog2(RspDepth);
  localparam int CntW = $clog2((WrHold > RdLatency ? WrHold : RdLatency) + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_STROBE  = 3'd1,
    ST_WR_HOLD    = 3'd2,
    ST_RD_STROBE  = 3'd3,
    ST_RD_WAIT    = 3'd4,
    ST_RD_CAPTURE = 3'd5,
    ST_WAIT_SLOT  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CntW-1:0]       r_cnt;
  logic [AddrWidth-3:0]  r_addr;
  logic [BusWidth-1:0]   r_data;
  logic [BusWidth-1:0]   r_fifo [RspDepth];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW:0]         r_count;
  logic [PtrW:0]         w_count_next;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_has_slot;
  logic                  w_last_beat;

`ifdef GPIO_INIT_AUTOINC_EN
  logic [3:0]            r_beats_left;
  logic                  w_next_beat;
  assign w_last_beat = (r_beats_left == 4'd0);
  assign w_next_beat = !w_last_beat &&
                       (((r_state == ST_WR_HOLD) && (r_cnt == '0)) || (r_state == ST_RD_CAPTURE));
`else
  assign w_last_beat = 1'b1;
`endif

  // Handshakes: a command transfers on the cycle cmd_valid && cmd_ready are both high; a
  // response is popped on the cycle rsp_valid && rsp_ready are both high. Neither side may
  // make its valid depend on the other side's ready.
  assign w_has_slot   = (r_count < (PtrW+1)'(RspDepth));
  assign cmd_ready    = (r_state == ST_IDLE) && (cmd_write || w_has_slot);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_push       = (r_state == ST_RD_CAPTURE);
  assign w_pop        = rsp_ready && (r_count != '0);
  assign w_count_next = r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:       if (w_accept) w_state_next = cmd_write ? ST_WR_STROBE : ST_RD_STROBE;
      ST_WR_STROBE:  w_state_next = ST_WR_HOLD;
      ST_WR_HOLD:    if (r_cnt == '0) w_state_next = w_last_beat ? ST_IDLE : ST_WR_STROBE;
      ST_RD_STROBE:  w_state_next = ST_RD_WAIT;
      ST_RD_WAIT:    if (r_cnt == '0) w_state_next = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        // The next burst beat must see room after this capture's push has landed.
        if (w_last_beat)                               w_state_next = ST_IDLE;
        else if (w_count_next < (PtrW+1)'(RspDepth))   w_state_next = ST_RD_STROBE;
        else                                           w_state_next = ST_WAIT_SLOT;
      end
      ST_WAIT_SLOT:  if (w_has_slot) w_state_next = ST_RD_STROBE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
`ifdef GPIO_INIT_AUTOINC_EN
      r_beats_left <= 4'd0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        case (w_state_next)
          ST_WR_HOLD: r_cnt <= CntW'(WrHold - 1);
          ST_RD_WAIT: r_cnt <= CntW'(RdLatency - 2);
          default:    r_cnt <= '0;
        endcase
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_data <= cmd_write ? cmd_data : '0;
`ifdef GPIO_INIT_AUTOINC_EN
        r_beats_left <= cmd_len;
`endif
      end
`ifdef GPIO_INIT_AUTOINC_EN
      else if (w_next_beat) begin
        r_addr       <= r_addr + (AddrWidth-2)'(1);
        r_beats_left <= r_beats_left - 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (w_push && !reset_in) r_fifo[r_wr_ptr] <= busdata_from_dec;
  end

  assign busy        = (r_state != ST_IDLE);
  assign chip_sel    = busy;
  assign write_reg   = (r_state == ST_WR_STROBE);
  assign read_reg    = (r_state == ST_RD_STROBE);
  assign busaddress  = busy ? r_addr : '0;
  assign busdata_out = busy ? r_data : '0;
  assign rsp_valid   = (r_count != '0);
  assign rsp_data    = rsp_valid ? r_fifo[r_rd_ptr] : '0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gpio_reg_bus_initiator.sv
// Bench for gpio_reg_bus_initiator: decoder memory with a fixed read pipeline, a
// transaction-timeline model compared every cycle, and directed plus random traffic.
module tb_gpio_reg_bus_initiator;
  localparam int DEPTH = 2;

  logic        reg_clk   = 1'b0;
  logic        reset_in  = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [13:0] cmd_addr  = '0;
  logic [31:0] cmd_data  = '0;
  logic        cmd_ready, rsp_valid, chip_sel, write_reg, read_reg, busy;
  logic [31:0] rsp_data, busdata_out, busdata_from_dec;
  logic [13:0] busaddress;
  logic [2:0]  dbg_state;
`ifdef GPIO_INIT_AUTOINC_EN
  logic [3:0]  cmd_len = 4'd0;
`endif

  gpio_reg_bus_initiator dut (
    .reg_clk(reg_clk), .reset_in(reset_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
`ifdef GPIO_INIT_AUTOINC_EN
    .cmd_len(cmd_len),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .chip_sel(chip_sel), .write_reg(write_reg), .read_reg(read_reg),
    .busaddress(busaddress), .busdata_out(busdata_out),
    .busdata_from_dec(busdata_from_dec), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 reg_clk = ~reg_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- decoder model: data valid only in the 4th cycle after the strobe -------
  logic [31:0] mem [16384];
  logic [31:0] dp [4];
  always @(posedge reg_clk) begin
    dp[0] <= read_reg ? mem[busaddress] : $urandom;
    dp[1] <= dp[0];
    dp[2] <= dp[1];
    dp[3] <= dp[2];
  end
  assign busdata_from_dec = dp[3];

  // ---------------- response-ready driver ----------------
  int rdy_mode = 0;
  always @(posedge reg_clk) begin
    #3;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard: transaction timeline model ----------------
  // ph 0 = idle, 1 = strobe cycle, 2..5 = hold/wait cycles; a read's data is queued after ph 5.
  logic [31:0] exp_q[$];
  int          ph = 0;
  logic        m_write = 1'b0;
  logic [13:0] m_addr  = '0;
  logic [31:0] m_data  = '0;
  bit          model_on = 1'b0;
  bit          exp_ready, acc;

  initial forever begin
    @(negedge reg_clk);
    if (model_on) begin
      exp_ready = (ph == 0) && (cmd_write || (exp_q.size() < DEPTH));
      chk("ctrl{ready,cs,busy,wr,rd,rspv}",
          {26'd0, cmd_ready, chip_sel, busy, write_reg, read_reg, rsp_valid},
          {26'd0, exp_ready, ph != 0, ph != 0, (ph == 1) && m_write, (ph == 1) && !m_write,
           exp_q.size() > 0});
      chk("busaddress", {18'd0, busaddress}, (ph != 0) ? {18'd0, m_addr} : 32'd0);
      chk("busdata_out", busdata_out, ((ph != 0) && m_write) ? m_data : 32'd0);
      chk("rsp_data", rsp_data, (exp_q.size() > 0) ? exp_q[0] : 32'd0);
      if (reset_in) begin
        ph = 0;
        exp_q.delete();
      end else begin
        acc = cmd_valid && exp_ready;
        if (rsp_ready && (exp_q.size() > 0)) void'(exp_q.pop_front());
        if ((ph == 5) && !m_write) exp_q.push_back(mem[m_addr]);
        if (ph == 5) ph = 0;
        else if (ph != 0) ph++;
        if (acc) begin
          ph = 1; m_write = cmd_write; m_addr = cmd_addr; m_data = cmd_data;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge reg_clk);
      #1;
    end
  endtask

  // Returns 2 time units into the first cycle after the accepting edge.
  task automatic send(input logic w, input logic [13:0] a, input logic [31:0] d);
    int   n;
    logic rdy;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
    n = 0;
    do begin
      @(negedge reg_clk);
      rdy = cmd_ready;
      @(posedge reg_clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: addr %h not accepted, want accept within 200 cycles", a);
    end
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_data  = $urandom;
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [13:0] ra;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[14'h400] = 32'h00123456;

    cyc(3);
    model_on = 1'b1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset strobes", {29'd0, write_reg, read_reg, chip_sel}, 32'd0);
    chk("reset state", {29'd0, dbg_state}, 32'd0);
    reset_in = 1'b0;
    cyc(1);

    // single write: strobe one cycle, address/data held strobe+hold, ready back after 6
    send(1'b1, 14'h440, 32'h00ABCDEF);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("t1 write_reg c%0d", k), {31'd0, write_reg}, (k == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t1 busaddress c%0d", k), {18'd0, busaddress}, (k <= 5) ? 32'h440 : 32'd0);
      chk($sformatf("t1 busdata_out c%0d", k), busdata_out, (k <= 5) ? 32'h00ABCDEF : 32'd0);
      chk($sformatf("t1 cmd_ready c%0d", k), {31'd0, cmd_ready}, (k == 6) ? 32'd1 : 32'd0);
      cyc(1);
    end

    // single read of 0x1000: response appears 6 cycles after the accept cycle
    rdy_mode = 0;
    send(1'b0, 14'h400, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("t2 read_reg c%0d", k), {31'd0, read_reg}, (k == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t2 rsp_valid c%0d", k), {31'd0, rsp_valid}, (k == 6) ? 32'd1 : 32'd0);
      cyc(1);
    end
    chk("t2 rsp_data", rsp_data, 32'h00123456);
    rdy_mode = 1; cyc(1); rdy_mode = 0; cyc(1);
    chk("t2 popped", {31'd0, rsp_valid}, 32'd0);

    // FIFO full: third read stalls until one pop frees a slot
    send(1'b0, 14'h010, 32'd0);
    send(1'b0, 14'h011, 32'd0);
    cyc(6);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h012;
    for (int k = 0; k < 3; k++) begin
      @(negedge reg_clk);
      chk($sformatf("t3 stall ready c%0d", k), {31'd0, cmd_ready}, 32'd0);
    end
    chk("t3 head", rsp_data, mem[14'h010]);
    @(posedge reg_clk); #1;
    rdy_mode = 1; cyc(1); rdy_mode = 0;
    send(1'b0, 14'h012, 32'd0);
    chk("t3 third strobe", {31'd0, read_reg}, 32'd1);
    chk("t3 third addr", {18'd0, busaddress}, 32'h012);
    rdy_mode = 1; cyc(12); rdy_mode = 0; cyc(1);
    chk("t3 drained", {31'd0, rsp_valid}, 32'd0);

    // push and pop on the same edge with one entry queued
    send(1'b0, 14'h020, 32'd0);
    cyc(6);
    send(1'b0, 14'h021, 32'd0);
    cyc(4);
    rdy_mode = 1; cyc(1); rdy_mode = 0;
    chk("t4 valid after push+pop", {31'd0, rsp_valid}, 32'd1);
    chk("t4 head after push+pop", rsp_data, mem[14'h021]);
    cyc(1);
    chk("t4 count held", {31'd0, rsp_valid}, 32'd1);
    rdy_mode = 1; cyc(2); rdy_mode = 0; cyc(1);
    chk("t4 drained", {31'd0, rsp_valid}, 32'd0);

    // reset while waiting for read data
    send(1'b0, 14'h030, 32'd0);
    cyc(1);
    reset_in = 1'b1;
    cyc(1);
    chk("t5 busy", {31'd0, busy}, 32'd0);
    chk("t5 strobes", {29'd0, write_reg, read_reg, chip_sel}, 32'd0);
    chk("t5 rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset_in = 1'b0;
    cyc(7);
    chk("t5 no capture", {31'd0, rsp_valid}, 32'd0);

    // random traffic with random consumer and occasional reset
    rdy_mode = 2;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_in = 1'b1; cyc(1); reset_in = 1'b0;
      end
      cyc($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom);
      send(1'($urandom_range(0, 1)), ra, $urandom);
    end
    rdy_mode = 1;
    cyc(20);
    chk("final drained", {31'd0, rsp_valid}, 32'd0);
    chk("final idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
